// File: rtl/key_pkg.sv
// key_pkg: shared state encoding, key channel indices and default timing
// constants for the key_conditioner push-button front-end.
package key_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DEB_ON  = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;
    localparam logic [1:0] ST_DEB_OFF = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        DEB_ON  = ST_DEB_ON,
        HELD    = ST_HELD,
        DEB_OFF = ST_DEB_OFF
    } key_state_t;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_ALARM = 2;

    localparam int DEF_NUM_KEYS     = 3;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_DEBOUNCE_CYC = 50000;
    localparam int DEF_REPEAT_DELAY = 5000000;
    localparam int DEF_REPEAT_RATE  = 1000000;

endpackage

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: raw key inputs and conditioned per-key outputs.
// slave = the conditioner, master = whoever drives the keys and consumes steps.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_step;
    logic [NUM_KEYS-1:0] key_rel;
    logic                key_any;

    modport master (
        output key_raw,
        input  key_level,
        input  key_step,
        input  key_rel,
        input  key_any
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_step,
        output key_rel,
        output key_any
    );
endinterface

// File: rtl/key_channel.sv
// key_channel: synchronizer, debounce FSM and auto-repeat timer for one key.
// Macro AUTO_REPEAT_EN builds the repeat timer; without it a held key
// produces exactly one step per accepted press.
//
// state   | meaning
// IDLE    | key released, waiting for synchronized press
// DEB_ON  | press seen, counting stable-high cycles
// HELD    | press accepted, level high, repeat timer running
// DEB_OFF | release seen, counting stable-low cycles, level still high
module key_channel
    import key_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_raw,
    output logic o_key_level,
    output logic o_key_step,
    output logic o_key_rel
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    key_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_rel;
    logic                   w_rep_step;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Shift the asynchronous key through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_key_raw};
    end

    // Debounce FSM: a level change is accepted only after DEBOUNCE_CYC stable samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
        end else begin
            r_press <= 1'b0;
            r_rel   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s) begin
                        r_state <= DEB_ON;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                DEB_ON: begin
                    if (!w_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!w_s) begin
                        r_state <= DEB_OFF;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                DEB_OFF: begin
                    if (w_s) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_rel   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_WD = $clog2(REPEAT_DELAY);
    localparam int REP_WR = $clog2(REPEAT_RATE);
    localparam int REP_WM = (REP_WD > REP_WR) ? REP_WD : REP_WR;
    localparam int REP_W  = (REP_WM > 0) ? REP_WM : 1;
    localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);
    localparam logic [REP_W-1:0] REP_MAX        = '1;

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_repeating;
    logic             r_rep_step;
    logic             w_accept_on;
    logic             w_accept_off;
    logic             w_rep_run;

    assign w_accept_on  = (r_state == DEB_ON) && w_s && (r_cnt == CNT_LAST);
    assign w_accept_off = (r_state == DEB_OFF) && !w_s && (r_cnt == CNT_LAST);
    // The timer only advances on samples where the key reads pressed, so a
    // short bounce during a hold pushes the cadence back by its own length.
    assign w_rep_run    = ((r_state == HELD) || (r_state == DEB_OFF)) && w_s;

    // Auto-repeat timer: first step after REPEAT_DELAY, then every REPEAT_RATE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt   <= '0;
            r_repeating <= 1'b0;
            r_rep_step  <= 1'b0;
        end else begin
            r_rep_step <= 1'b0;
            if (w_accept_on) begin
                r_rep_cnt   <= '0;
                r_repeating <= 1'b0;
            end else if (w_accept_off) begin
                r_repeating <= 1'b0;
            end else if (w_rep_run) begin
                if (!r_repeating && (r_rep_cnt == REP_DELAY_LAST)) begin
                    r_rep_step  <= 1'b1;
                    r_rep_cnt   <= '0;
                    r_repeating <= 1'b1;
                end else if (r_repeating && (r_rep_cnt == REP_RATE_LAST)) begin
                    r_rep_step <= 1'b1;
                    r_rep_cnt  <= '0;
                end else if (r_rep_cnt != REP_MAX) begin
                    r_rep_cnt <= r_rep_cnt + REP_W'(1);
                end
            end
        end
    end

    assign w_rep_step = r_rep_step;
`else
    logic w_unused_rep_cfg;
    assign w_unused_rep_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
    assign w_rep_step       = 1'b0;
`endif

    // Press and repeat pulses come from disjoint states, so the OR never merges two events.
    assign o_key_step  = r_press | w_rep_step;
    assign o_key_level = r_level;
    assign o_key_rel   = r_rel;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounced level, press/repeat step and release pulses for
// the clock/alarm panel keys. One key_channel per key; key_any ORs the levels.
// Macro AUTO_REPEAT_EN enables auto-repeat steps while a key is held.
module key_conditioner
    import key_pkg::*;
#(
    parameter int NUM_KEYS     = DEF_NUM_KEYS,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic               clk,
    input  logic               rst,
    key_conditioner_if.slave   kif
);
    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_step;
    logic [NUM_KEYS-1:0] w_rel;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_key_raw   (kif.key_raw[g]),
            .o_key_level (w_level[g]),
            .o_key_step  (w_step[g]),
            .o_key_rel   (w_rel[g])
        );
    end

    assign kif.key_level = w_level;
    assign kif.key_step  = w_step;
    assign kif.key_rel   = w_rel;
    assign kif.key_any   = |w_level;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed key scenarios followed by random key
// activity, checked cycle by cycle against a run-length reference model.
module tb_key_conditioner;
    import key_pkg::*;

    localparam int NK  = 3;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;

    typedef struct packed {
        logic [NK-1:0] lvl;
        logic [NK-1:0] step;
        logic [NK-1:0] rel;
        logic          any;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_conditioner_if #(.NUM_KEYS(NK)) kif ();

    key_conditioner #(
        .NUM_KEYS     (NK),
        .SYNC_STAGES  (2),
        .DEBOUNCE_CYC (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_step[NK];
    int   mon_rel[NK];

    // Reference model: synchronizer samples plus run lengths of the
    // synchronized key and a count of pressed samples since acceptance.
    logic m_sy1[NK];
    logic m_sy2[NK];
    logic m_lvl[NK];
    int   m_run1[NK];
    int   m_run0[NK];
    int   m_act[NK];

    function automatic bit is_repeat(input int n);
        return (n == RD) || ((n > RD) && (((n - RD) % RR) == 0));
    endfunction

    task automatic model_edge(input logic r, input logic [NK-1:0] raw);
        exp_t e;
        logic s_k;
        e = '0;
        for (int k = 0; k < NK; k++) begin
            if (r) begin
                m_sy1[k] = 1'b0; m_sy2[k] = 1'b0; m_lvl[k] = 1'b0;
                m_run1[k] = 0; m_run0[k] = 0; m_act[k] = 0;
            end else begin
                s_k = m_sy2[k];
                if (s_k) begin m_run1[k]++; m_run0[k] = 0; end
                else     begin m_run0[k]++; m_run1[k] = 0; end
                if (!m_lvl[k] && (m_run1[k] >= DEB)) begin
                    m_lvl[k] = 1'b1; e.step[k] = 1'b1; m_act[k] = 0;
                end else if (m_lvl[k] && (m_run0[k] >= DEB)) begin
                    m_lvl[k] = 1'b0; e.rel[k] = 1'b1;
                end else if (m_lvl[k] && s_k) begin
                    m_act[k]++;
`ifdef AUTO_REPEAT_EN
                    if (is_repeat(m_act[k])) e.step[k] = 1'b1;
`endif
                end
                m_sy2[k] = m_sy1[k];
                m_sy1[k] = raw[k];
            end
            e.lvl[k] = m_lvl[k];
        end
        e.any = |e.lvl;
        q.push_back(e);
    endtask

    task automatic tick(input logic r, input logic [NK-1:0] raw);
        @(negedge clk);
        rst = r;
        kif.key_raw = raw;
        model_edge(r, raw);
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n, input logic r, input logic [NK-1:0] raw);
        for (int i = 0; i < n; i++) tick(r, raw);
    endtask

    task automatic check_cnt(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: pops one expectation per clock edge and compares all outputs.
    initial begin
        exp_t e;
        exp_t got;
        for (int k = 0; k < NK; k++) begin mon_step[k] = 0; mon_rel[k] = 0; end
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                got = {kif.key_level, kif.key_step, kif.key_rel, kif.key_any};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t lvl got %b exp %b step got %b exp %b rel got %b exp %b any got %b exp %b",
                             $time, got.lvl, e.lvl, got.step, e.step, got.rel, e.rel, got.any, e.any);
                end
                for (int k = 0; k < NK; k++) begin
                    if (kif.key_step[k] === 1'b1) mon_step[k]++;
                    if (kif.key_rel[k] === 1'b1)  mon_rel[k]++;
                end
            end
        end
    end

    // Stimulus: directed scenarios, then random key activity.
    initial begin
        int           s0, r0;
        int           hold[NK];
        logic [NK-1:0] tgt;

        kif.key_raw = '0;
        for (int k = 0; k < NK; k++) begin
            m_sy1[k] = 1'b0; m_sy2[k] = 1'b0; m_lvl[k] = 1'b0;
            m_run1[k] = 0; m_run0[k] = 0; m_act[k] = 0;
            hold[k] = 0;
        end
        tgt = '0;

        // Reset with all keys pressed, then acceptance 6 cycles after release of rst.
        run(3, 1'b1, 3'b111);
        s0 = mon_step[KEY_UP];
        run(6, 1'b0, 3'b111);
        check_cnt("step_after_reset", mon_step[KEY_UP] - s0, 1);
        check_cnt("level_after_reset", int'(kif.key_level), 7);
        run(12, 1'b0, 3'b000);

        // Bouncing press on key 0.
        s0 = mon_step[KEY_UP];
        run(1, 1'b0, 3'b001); run(1, 1'b0, 3'b000);
        run(1, 1'b0, 3'b001); run(1, 1'b0, 3'b000);
        run(5, 1'b0, 3'b001);
        check_cnt("bounce_no_early_step", mon_step[KEY_UP] - s0, 0);
        run(1, 1'b0, 3'b001);
        check_cnt("bounce_single_step", mon_step[KEY_UP] - s0, 1);
        run(6, 1'b0, 3'b001);

        // Short low glitch during hold: no release, cadence shifted.
        r0 = mon_rel[KEY_UP];
        run(2, 1'b0, 3'b000);
        run(20, 1'b0, 3'b001);
        check_cnt("glitch_no_rel", mon_rel[KEY_UP] - r0, 0);
        run(8, 1'b0, 3'b000);
        check_cnt("key0_release", mon_rel[KEY_UP] - r0, 1);

        // Long hold on key 1: press step plus repeat cadence.
        s0 = mon_step[KEY_DOWN];
        r0 = mon_rel[KEY_DOWN];
        run(34, 1'b0, 3'b010);
        run(10, 1'b0, 3'b000);
`ifdef AUTO_REPEAT_EN
        check_cnt("repeat_count", mon_step[KEY_DOWN] - s0, 8);
`else
        check_cnt("repeat_count", mon_step[KEY_DOWN] - s0, 1);
`endif
        check_cnt("key1_release", mon_rel[KEY_DOWN] - r0, 1);

        // Clean press and release of key 2.
        r0 = mon_rel[KEY_ALARM];
        run(12, 1'b0, 3'b100);
        run(8, 1'b0, 3'b000);
        check_cnt("key2_release", mon_rel[KEY_ALARM] - r0, 1);
        check_cnt("key_any_low", int'(kif.key_any), 0);

        // Reset while key 0 is repeating, then re-acceptance.
        r0 = mon_rel[KEY_UP];
        run(25, 1'b0, 3'b001);
        run(1, 1'b1, 3'b001);
        check_cnt("rst_level_drop", int'(kif.key_level), 0);
        s0 = mon_step[KEY_UP];
        run(6, 1'b0, 3'b001);
        check_cnt("rst_reaccept", mon_step[KEY_UP] - s0, 1);
        check_cnt("rst_no_rel", mon_rel[KEY_UP] - r0, 0);
        run(10, 1'b0, 3'b000);

        // Random activity on all keys with occasional reset.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (hold[k] == 0) begin
                    tgt[k] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) hold[k] = int'($urandom_range(1, 3));
                    else                           hold[k] = int'($urandom_range(4, 40));
                end
                hold[k]--;
            end
            tick(($urandom_range(0, 599) == 0), tgt);
        end
        run(12, 1'b0, 3'b000);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
